// File: rtl/umem_pkg.sv
// Shared definitions for the unified memory controller: FSM state encoding
// and the default MMIO register address.
package umem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t RESP = 2'd2;

  localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'hFFFF_FFF0;

endpackage

// File: rtl/umem_bram.sv
// Word-organised storage array: byte-enabled synchronous write port and an
// asynchronous read port sharing one word index. Contents are never reset.
module umem_bram
  import umem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write: only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/unified_mem_ctrl.sv
// Single-port memory controller with a fixed wait-state count per access.
// IDLE accepts a request, WAIT burns WAIT_STATES cycles, RESP emits a
// one-cycle response. Optional MMIO output register enabled by the macro
// UMEM_MMIO_EN (adds ports mmio_out / mmio_strobe).
module unified_mem_ctrl
  import umem_pkg::*;
#(
  parameter int unsigned  DATA_W      = 32,
  parameter int unsigned  DEPTH       = 256,
  parameter int unsigned  WAIT_STATES = 2,
  parameter logic [31:0]  MMIO_ADDR   = MMIO_ADDR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [DATA_W/8-1:0]  req_be,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err
`ifdef UMEM_MMIO_EN
  ,
  output logic [DATA_W-1:0]    mmio_out,
  output logic                 mmio_strobe
`endif
);

  localparam int unsigned BYTES     = DATA_W / 8;
  localparam int unsigned OFF_W     = $clog2(BYTES);
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] OFF_MASK  = 32'(BYTES - 1);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH) * 33'(BYTES);
  localparam logic [3:0]  WS_M1     = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef UMEM_MMIO_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                lat_we_q, lat_we_d;
  logic [31:0]         lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
  logic [BYTES-1:0]    lat_be_q, lat_be_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
`ifdef UMEM_MMIO_EN
  logic [DATA_W-1:0]   mmio_q, mmio_d;
  logic                strobe_q, strobe_d;
`endif

  logic                in_idle, enter_resp;
  logic                acc_we, misaligned, out_of_range, is_mmio, acc_err;
  logic [31:0]         acc_addr;
  logic [DATA_W-1:0]   acc_wdata, mem_rdata;
  logic [BYTES-1:0]    acc_be;
  logic [IDX_W-1:0]    acc_idx;
  logic                mem_we;

  assign in_idle   = (state_q == IDLE);
  assign req_ready = reset & in_idle;

  // With zero wait states the access completes on the accept edge, so the
  // decode works on the live request in IDLE and on the latched copy otherwise.
  always_comb begin
    acc_we       = in_idle ? req_we    : lat_we_q;
    acc_addr     = in_idle ? req_addr  : lat_addr_q;
    acc_wdata    = in_idle ? req_wdata : lat_wdata_q;
    acc_be       = in_idle ? req_be    : lat_be_q;
    acc_idx      = acc_addr[OFF_W +: IDX_W];
    misaligned   = (acc_addr & OFF_MASK) != '0;
    out_of_range = {1'b0, acc_addr} >= MEM_BYTES;
    is_mmio      = MMIO_EN && (acc_addr == MMIO_ADDR);
    acc_err      = misaligned | (out_of_range & ~is_mmio);
  end

  // Next-state, counter, response and write-enable logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_be_d    = lat_be_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    enter_resp  = 1'b0;
    mem_we      = 1'b0;
`ifdef UMEM_MMIO_EN
    mmio_d      = mmio_q;
    strobe_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          lat_we_d    = req_we;
          lat_addr_d  = req_addr;
          lat_wdata_d = req_wdata;
          lat_be_d    = req_be;
          if (WAIT_STATES == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) enter_resp = 1'b1;
        else             cnt_d      = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enter_resp && reset) begin
      state_d     = RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      mem_we      = acc_we & ~acc_err & ~is_mmio;
`ifdef UMEM_MMIO_EN
      if (!acc_we && !acc_err) rsp_rdata_d = is_mmio ? mmio_q : mem_rdata;
      if (acc_we && is_mmio && !acc_err) begin
        strobe_d = 1'b1;
        for (int unsigned i = 0; i < BYTES; i++) begin
          if (acc_be[i]) mmio_d[8*i +: 8] = acc_wdata[8*i +: 8];
        end
      end
`else
      if (!acc_we && !acc_err) rsp_rdata_d = mem_rdata;
`endif
    end
  end

  // Control and response state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef UMEM_MMIO_EN
      mmio_q      <= '0;
      strobe_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef UMEM_MMIO_EN
      mmio_q      <= mmio_d;
      strobe_q    <= strobe_d;
`endif
    end
  end

  // Request capture registers; no reset needed, only read outside IDLE.
  always_ff @(posedge clk) begin
    lat_we_q    <= lat_we_d;
    lat_addr_q  <= lat_addr_d;
    lat_wdata_q <= lat_wdata_d;
    lat_be_q    <= lat_be_d;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef UMEM_MMIO_EN
  assign mmio_out    = mmio_q;
  assign mmio_strobe = strobe_q;
`endif

  umem_bram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bram (
    .clk   (clk),
    .we    (mem_we),
    .be    (acc_be),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed bench for unified_mem_ctrl: instance A uses two wait states,
// instance B zero wait states. MMIO checks run only with UMEM_MMIO_EN.
module tb_unified_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        a_valid = 1'b0, a_we = 1'b0, a_ready, a_rsp_valid, a_err;
  logic [31:0] a_addr = '0, a_wdata = '0, a_rdata;
  logic [3:0]  a_be = '0;

  logic        b_valid = 1'b0, b_we = 1'b0, b_ready, b_rsp_valid, b_err;
  logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;
  logic [3:0]  b_be = '0;

`ifdef UMEM_MMIO_EN
  logic [31:0] a_mmio_out, b_mmio_out;
  logic        a_strobe, b_strobe;
  int          strobe_cnt = 0;
  always @(posedge clk) if (a_strobe) strobe_cnt <= strobe_cnt + 1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  unified_mem_ctrl #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready),
    .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err)
`ifdef UMEM_MMIO_EN
    , .mmio_out(a_mmio_out), .mmio_strobe(a_strobe)
`endif
  );

  unified_mem_ctrl #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready),
    .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err)
`ifdef UMEM_MMIO_EN
    , .mmio_out(b_mmio_out), .mmio_strobe(b_strobe)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on instance A; caller is positioned #1 after a rising edge.
  task automatic access_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata,
                          output logic err, output int lat);
    int n;
    a_we = we; a_addr = addr; a_wdata = wdata; a_be = be; a_valid = 1'b1;
    n = 0;
    while (!a_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    a_valid = 1'b0; a_we = ~we; a_addr = 32'h44; a_wdata = ~wdata; a_be = ~be;
    lat = 1;
    while (!a_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("a_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
    chk("a_ready_in_resp", {31'd0, a_ready}, 32'd0);
    rdata = a_rdata;
    err   = a_err;
    @(posedge clk); #1;
    chk("a_rsp_pulse_end", {31'd0, a_rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_a_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_a_rsp_err", {31'd0, a_err}, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_a_ready", {31'd0, a_ready}, 32'd1);

    // Write then read back, latency WAIT_STATES+1
    access_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("wr10_lat", 32'(lat), 32'd3);
    chk("wr10_err", {31'd0, er}, 32'd0);
    chk("wr10_rdata", rd, 32'd0);
    access_a(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd10_lat", 32'(lat), 32'd3);
    chk("rd10_err", {31'd0, er}, 32'd0);
    chk("rd10_rdata", rd, 32'hDEADBEEF);

    // Byte-enable merge and be=0 write
    access_a(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    access_a(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    access_a(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    chk("rd20_merge", rd, 32'h11BB33DD);
    access_a(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    chk("wr20_be0_err", {31'd0, er}, 32'd0);
    access_a(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("rd20_be0", rd, 32'h11BB33DD);

    // Error accesses: misaligned and out of range, no side effects
    access_a(1'b0, 32'h02, 32'h0, 4'hF, rd, er, lat);
    chk("rd02_err", {31'd0, er}, 32'd1);
    chk("rd02_rdata", rd, 32'd0);
    access_a(1'b0, 32'h400, 32'h0, 4'hF, rd, er, lat);
    chk("rd400_err", {31'd0, er}, 32'd1);
    chk("rd400_rdata", rd, 32'd0);
    access_a(1'b1, 32'h04, 32'h01234567, 4'hF, rd, er, lat);
    access_a(1'b1, 32'h404, 32'hCAFEF00D, 4'hF, rd, er, lat);
    chk("wr404_err", {31'd0, er}, 32'd1);
    access_a(1'b1, 32'h12, 32'h0BADC0DE, 4'hF, rd, er, lat);
    chk("wr12_err", {31'd0, er}, 32'd1);
    access_a(1'b0, 32'h04, 32'h0, 4'h0, rd, er, lat);
    chk("rd04_unchanged", rd, 32'h01234567);
    access_a(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd10_unchanged", rd, 32'hDEADBEEF);

    // Reset during WAIT of a write aborts it
    access_a(1'b1, 32'h30, 32'h0000AAAA, 4'hF, rd, er, lat);
    a_we = 1'b1; a_addr = 32'h30; a_wdata = 32'hFFFFFFFF; a_be = 4'hF; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk("abort_in_wait_ready", {31'd0, a_ready}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_rst_ready", {31'd0, a_ready}, 32'd0);
    chk("abort_rst_rsp", {31'd0, a_rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("abort_rst_rsp2", {31'd0, a_rsp_valid}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_rel_ready", {31'd0, a_ready}, 32'd1);
    chk("abort_rel_rsp", {31'd0, a_rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("abort_rel_rsp2", {31'd0, a_rsp_valid}, 32'd0);
    access_a(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    chk("rd30_after_abort", rd, 32'h0000AAAA);
    access_a(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("rd10_after_reset", rd, 32'hDEADBEEF);

    // Zero wait states, back-to-back writes: one access per two cycles
    b_we = 1'b1; b_addr = 32'h40; b_wdata = 32'h55; b_be = 4'hF; b_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("b_rsp_valid", {31'd0, b_rsp_valid}, 32'(i % 2));
      chk("b_ready", {31'd0, b_ready}, 32'(1 - (i % 2)));
      if (i % 2 == 1) chk("b_wr_rdata", b_rdata, 32'd0);
      @(posedge clk); #1;
    end
    b_we = 1'b0;
    @(posedge clk); #1;
    b_valid = 1'b0;
    chk("b_rd_rsp_valid", {31'd0, b_rsp_valid}, 32'd1);
    chk("b_rd_rdata", b_rdata, 32'h55);
    chk("b_rd_err", {31'd0, b_err}, 32'd0);
    @(posedge clk); #1;
    chk("b_idle_rsp", {31'd0, b_rsp_valid}, 32'd0);

`ifdef UMEM_MMIO_EN
    access_a(1'b1, 32'hFFFF_FFF0, 32'h5, 4'hF, rd, er, lat);
    chk("mmio_wr_err", {31'd0, er}, 32'd0);
    chk("mmio_out", a_mmio_out, 32'h5);
    repeat (2) @(posedge clk);
    #1;
    chk("mmio_strobe_cnt", 32'(strobe_cnt), 32'd1);
    access_a(1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0, rd, er, lat);
    chk("mmio_rd", rd, 32'h5);
    chk("mmio_rd_err", {31'd0, er}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_ctrl.md
UNIFIED_MEM_CTRL -- requirements
Module: unified_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 256, number of DATA_W-bit words; SHALL be a power of two.
REQ-003 Parameter WAIT_STATES, default 2, extra cycles per access; legal range 0..15.
REQ-004 Parameter MMIO_ADDR, default 32'hFFFF_FFF0, byte address of the output register.
REQ-005 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-006 reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on rising clk).
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 req_be  input  DATA_W/8  byte enables for writes.
REQ-013 rsp_valid  output  1  one-cycle response pulse.
REQ-014 rsp_rdata  output  DATA_W  read data, valid while rsp_valid=1.
REQ-015 rsp_err  output  1  access error flag, valid while rsp_valid=1.
REQ-016 mmio_out  output  DATA_W  MMIO register contents (present only with UMEM_MMIO_EN).
REQ-017 mmio_strobe  output  1  one-cycle pulse on an MMIO write (present only with UMEM_MMIO_EN).

Function
REQ-018 FSM states SHALL be IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Accept occurs when req_valid & req_ready; the block SHALL latch we, addr, wdata and be on accept.
REQ-020 On accept, IDLE SHALL go to WAIT with a down-counter loaded to WAIT_STATES-1, or go directly to RESP if WAIT_STATES=0.
REQ-021 WAIT SHALL decrement the counter each cycle and go to RESP after the cycle in which the counter equals 0.
REQ-022 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; a new request SHALL be acceptable on the following cycle.
REQ-023 Latency from the accept edge to rsp_valid high SHALL be WAIT_STATES+1 cycles; throughput SHALL be one access per WAIT_STATES+2 cycles.
REQ-024 Word index SHALL be addr[log2(DATA_W/8)+log2(DEPTH)-1 : log2(DATA_W/8)].
REQ-025 An access SHALL be an error (rsp_err=1) if the addr low byte-offset bits are nonzero, or if addr is at or above DEPTH*DATA_W/8 and is not MMIO_ADDR.
REQ-026 An erroneous access SHALL perform no write and SHALL return rsp_rdata=0.
REQ-027 A valid write SHALL update only enabled bytes, on the clock edge that enters RESP; rsp_rdata on a write response SHALL be 0.
REQ-028 A read SHALL return the word content as of the RESP-entry edge, so a read after a write to the same address returns the new data.
REQ-029 req_be SHALL be ignored for reads; a write with req_be=0 SHALL complete normally and change nothing.
REQ-030 Request inputs outside IDLE SHALL be ignored; no queueing is provided.

Reset
REQ-031 While reset=0, the block SHALL enter IDLE and clear the counter, rsp_valid, rsp_err, rsp_rdata, mmio_out and mmio_strobe to 0.
REQ-032 While reset=0, req_ready SHALL be 0; it SHALL become 1 in the first cycle after reset is deasserted.
REQ-033 Reset during WAIT or RESP SHALL abort the access with no write and no response; memory array contents SHALL NOT be cleared.

Configuration
REQ-034 Macro UMEM_MMIO_EN: when defined, a valid aligned write to MMIO_ADDR SHALL update mmio_out under req_be and pulse mmio_strobe with rsp_valid, and a read of MMIO_ADDR SHALL return mmio_out.
REQ-035 When UMEM_MMIO_EN is not defined, ports mmio_out and mmio_strobe SHALL be absent and MMIO_ADDR SHALL be treated as an ordinary address subject to REQ-025.

Structure
REQ-036 Package umem_pkg SHALL hold the FSM state typedef (IDLE/WAIT/RESP) and the default MMIO_ADDR constant.
REQ-037 The storage array SHALL be a sub-module, umem_bram, with a byte-enabled synchronous write port and an asynchronous read port; the FSM and decode SHALL stay in unified_mem_ctrl.

Verification
REQ-038 Scenario: WAIT_STATES=2, write 32'hDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> rsp_valid 3 cycles after each accept, rdata=32'hDEADBEEF, err=0.
REQ-039 Scenario: write 32'h11223344 to 0x20 (be=F), then write 32'hAABBCCDD with be=4'b0101, then read 0x20 -> rdata=32'h11BB33DD.
REQ-040 Scenario: reads of 0x02 and of 0x400 (DEPTH=256) -> rsp_err=1, rdata=0, memory unchanged.
REQ-041 Scenario: WAIT_STATES=0, back-to-back requests -> rsp_valid 1 cycle after each accept, req_ready low in RESP, one access per 2 cycles.
REQ-042 Scenario: reset=0 asserted during WAIT of a write -> no rsp_valid, target word unchanged, req_ready=1 the cycle after release.
REQ-043 Scenario: with UMEM_MMIO_EN defined, write 32'h5 to MMIO_ADDR -> mmio_out=5, mmio_strobe pulses once; a read of MMIO_ADDR returns 5.
